// File: rtl/ureg_xfer_ctrl_pkg.sv
// Shared types for the universal shift register transfer controller.
// Register mode encodings, controller states and default widths.
package ureg_ctrl_pkg;
   localparam int UREG_DATA_W = 8;
   localparam int UREG_CNT_W  = 4;

   typedef enum logic [1:0] {
      MODE_SISO = 2'b00,
      MODE_SIPO = 2'b01,
      MODE_PISO = 2'b10,
      MODE_PIPO = 2'b11
   } ureg_mode_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_TX_LOAD,
      ST_TX_SHIFT,
      ST_RX_SHIFT,
      ST_RX_DONE,
      ST_SCRUB
   } ureg_ctrl_state_e;
endpackage

// File: rtl/ureg_xfer_ctrl_if.sv
// Host handshakes plus shift-register control pins of the transfer controller.
// slave = controller side, master = host/register side.
interface ureg_xfer_ctrl_if #(parameter int DATA_W = ureg_ctrl_pkg::UREG_DATA_W);
   import ureg_ctrl_pkg::*;

   logic              tx_valid;
   logic              tx_ready;
   logic [DATA_W-1:0] tx_data;
   logic              tx_done;
   logic              rx_req;
   logic              rx_valid;
   logic              rx_ready;
   logic [DATA_W-1:0] rx_data;
   logic              rx_err;
   logic              busy;
   logic              reg_enable;
   ureg_mode_e        reg_mode;
   logic              reg_load;
   logic [DATA_W-1:0] reg_parallel_in;
   logic [DATA_W-1:0] reg_parallel_out;
   logic              err_corr;
   logic              err_uncorr;
   logic [7:0]        scrub_cnt;

   modport master (
      output tx_valid, tx_data, rx_req, rx_ready, reg_parallel_out, err_corr, err_uncorr,
      input  tx_ready, tx_done, rx_valid, rx_data, rx_err, busy,
             reg_enable, reg_mode, reg_load, reg_parallel_in, scrub_cnt
   );

   modport slave (
      input  tx_valid, tx_data, rx_req, rx_ready, reg_parallel_out, err_corr, err_uncorr,
      output tx_ready, tx_done, rx_valid, rx_data, rx_err, busy,
             reg_enable, reg_mode, reg_load, reg_parallel_in, scrub_cnt
   );
endinterface

// File: rtl/ureg_bit_counter.sv
// Frame bit counter: synchronous clear beats increment; term flags the last bit (DATA_W-1).
// Single-cycle update, no backpressure.
module ureg_bit_counter #(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic inc,
   output logic term
);
   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)       cnt_q <= '0;
      else if (clr)   cnt_q <= '0;
      else if (inc)   cnt_q <= cnt_q + CNT_W'(1);
   end

   assign term = (cnt_q == CNT_W'(DATA_W - 1));
endmodule

// File: rtl/ureg_xfer_ctrl.sv
// Sequences shift-register control for TX (load + DATA_W PISO shifts) and RX (DATA_W SIPO shifts);
// RX beats TX, RX_DONE holds until rx_ready. Optional scrub write-back under UREG_CTRL_SCRUB_EN.
module ureg_xfer_ctrl
   import ureg_ctrl_pkg::*;
#(
   parameter int DATA_W = UREG_DATA_W,
   parameter int CNT_W  = UREG_CNT_W
) (
   input logic             clk,
   input logic             rst,
   ureg_xfer_ctrl_if.slave bus
);
   ureg_ctrl_state_e  state_q, state_d;
   logic              run_q;
   logic [DATA_W-1:0] tx_q;
   logic              scrub_pend;
   logic [7:0]        scrub_cnt_q;
   logic              rx_err_q;
   logic              shifting, cnt_term;
   logic              tx_ready_c, tx_done_c, rx_valid_c;
   logic              reg_enable_c, reg_load_c;
   ureg_mode_e        reg_mode_c;
   logic [DATA_W-1:0] reg_pin_c;

   assign shifting = (state_q == ST_TX_SHIFT) || (state_q == ST_RX_SHIFT);

   ureg_bit_counter #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_cnt (
      .clk  (clk),
      .rst  (rst),
      .clr  (!shifting || cnt_term),
      .inc  (shifting),
      .term (cnt_term)
   );

   // run_q keeps tx_ready low while reset is asserted even though state is IDLE.
   assign tx_ready_c = run_q && (state_q == ST_IDLE) && !bus.rx_req && !scrub_pend;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         run_q   <= 1'b0;
         tx_q    <= '0;
      end else begin
         state_q <= state_d;
         run_q   <= 1'b1;
         if (tx_ready_c && bus.tx_valid) tx_q <= bus.tx_data;
      end
   end

   always_comb begin
      state_d      = state_q;
      reg_enable_c = 1'b0;
      reg_mode_c   = MODE_SISO;
      reg_load_c   = 1'b0;
      reg_pin_c    = '0;
      tx_done_c    = 1'b0;
      rx_valid_c   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (run_q) begin
               if (bus.rx_req)                 state_d = ST_RX_SHIFT;
               else if (scrub_pend)            state_d = ST_SCRUB;
               else if (bus.tx_valid)          state_d = ST_TX_LOAD;
            end
         end
         ST_TX_LOAD: begin
            reg_enable_c = 1'b1;
            reg_mode_c   = MODE_PISO;
            reg_load_c   = 1'b1;
            reg_pin_c    = tx_q;
            state_d      = ST_TX_SHIFT;
         end
         ST_TX_SHIFT: begin
            reg_enable_c = 1'b1;
            reg_mode_c   = MODE_PISO;
            if (cnt_term) begin
               tx_done_c = 1'b1;
               state_d   = ST_IDLE;
            end
         end
         ST_RX_SHIFT: begin
            reg_enable_c = 1'b1;
            reg_mode_c   = MODE_SIPO;
            if (cnt_term) state_d = ST_RX_DONE;
         end
         ST_RX_DONE: begin
            rx_valid_c = 1'b1;
            if (bus.rx_ready) state_d = ST_IDLE;
         end
         ST_SCRUB: begin
            // Write the decoder-corrected byte back so the stored codeword is clean again.
            reg_enable_c = 1'b1;
            reg_mode_c   = MODE_PIPO;
            reg_load_c   = 1'b1;
            reg_pin_c    = bus.reg_parallel_out;
            state_d      = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

`ifdef UREG_CTRL_SCRUB_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         scrub_pend  <= 1'b0;
         scrub_cnt_q <= '0;
         rx_err_q    <= 1'b0;
      end else begin
         if (state_q == ST_SCRUB)
            scrub_pend <= 1'b0;
         else if (bus.err_corr && (state_q == ST_IDLE || state_q == ST_RX_DONE))
            scrub_pend <= 1'b1;
         if (state_q == ST_SCRUB && scrub_cnt_q != 8'hFF)
            scrub_cnt_q <= scrub_cnt_q + 8'd1;
         if (state_q == ST_RX_SHIFT && cnt_term)
            rx_err_q <= bus.err_uncorr;
      end
   end
`else
   assign scrub_pend  = 1'b0;
   assign scrub_cnt_q = '0;
   assign rx_err_q    = 1'b0;
`endif

   assign bus.tx_ready        = tx_ready_c;
   assign bus.tx_done         = tx_done_c;
   assign bus.rx_valid        = rx_valid_c;
   assign bus.rx_data         = rx_valid_c ? bus.reg_parallel_out : '0;
   assign bus.rx_err          = rx_valid_c && rx_err_q;
   assign bus.busy            = (state_q != ST_IDLE);
   assign bus.reg_enable      = reg_enable_c;
   assign bus.reg_mode        = reg_mode_c;
   assign bus.reg_load        = reg_load_c;
   assign bus.reg_parallel_in = reg_pin_c;
   assign bus.scrub_cnt       = scrub_cnt_q;
endmodule

// File: tb/tb_ureg_xfer_ctrl.sv
// Bench for ureg_xfer_ctrl: behavioural shift register, vector table of TX/RX frames, scoreboard of
// expected register loads and received bytes, plus reset and scrub sequences.
module tb_ureg_xfer_ctrl;
   import ureg_ctrl_pkg::*;

`ifdef UREG_CTRL_SCRUB_EN
   localparam bit SCRUB = 1'b1;
`else
   localparam bit SCRUB = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n;
   logic serial_in;
   logic [7:0] reg_q;

   int checks = 0;
   int failures = 0;
   int piso_n = 0;
   int sipo_n = 0;
   int done_cnt = 0;
   bit rx_seen = 0;

   typedef struct {
      logic [1:0] mode;
      logic [7:0] data;
   } exp_t;
   exp_t sb[$];

   typedef struct {
      bit         is_rx;
      logic [7:0] data;
      bit         with_tx;
      logic [7:0] tx_d;
      bit         uncorr;
      int         exp_lat;
   } vec_t;
   vec_t vec[7];

   always #5 clk = ~clk;

   ureg_xfer_ctrl_if #(.DATA_W(8)) u_if ();

   ureg_xfer_ctrl #(.DATA_W(8), .CNT_W(4)) dut (
      .clk (clk),
      .rst (rst_n),
      .bus (u_if.slave)
   );

   // Behavioural register: shifts left, serial_in enters at the LSB.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) reg_q <= '0;
      else if (u_if.reg_enable) begin
         if (u_if.reg_load) reg_q <= u_if.reg_parallel_in;
         else if (u_if.reg_mode == MODE_SIPO || u_if.reg_mode == MODE_PISO)
            reg_q <= {reg_q[6:0], serial_in};
      end
   end
   assign u_if.reg_parallel_out = reg_q;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h want=%0h", name, got, exp);
      end
   endtask

   task automatic pop_cmp(input string name, input logic [1:0] mode, input logic [7:0] data);
      exp_t e;
      check({name, "_expected"}, sb.size() > 0, 1);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check({name, "_mode"}, mode, e.mode);
         check({name, "_data"}, data, e.data);
      end
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         piso_n  = 0;
         sipo_n  = 0;
         rx_seen = 0;
      end else begin
         check("tx_ready_while_busy", u_if.busy & u_if.tx_ready, 0);
         if (u_if.reg_enable && !u_if.reg_load && u_if.reg_mode == MODE_PISO) piso_n++;
         if (u_if.reg_enable && u_if.reg_mode == MODE_SIPO) sipo_n++;
         if (u_if.tx_done) begin
            done_cnt++;
            check("tx_shift_count", piso_n, 8);
            piso_n = 0;
         end
         if (u_if.rx_valid && !rx_seen) begin
            check("rx_shift_count", sipo_n, 8);
            sipo_n = 0;
         end
         rx_seen = u_if.rx_valid;
         if (u_if.reg_load) pop_cmp("load", u_if.reg_mode, u_if.reg_parallel_in);
         if (u_if.rx_valid && u_if.rx_ready) pop_cmp("rx", MODE_SIPO, u_if.rx_data);
      end
   end

   // Entered at the negedge of handshake cycle N; lat = cycles from N to tx_done.
   task automatic tx_post(output int lat);
      @(posedge clk); #1 u_if.tx_valid = 1'b0;
      @(negedge clk);
      check("tx_load_at_n1", u_if.reg_load, 1);
      lat = 1;
      while (!u_if.tx_done && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      @(negedge clk);
      check("tx_ready_after_done", u_if.tx_ready, 1);
   endtask

   task automatic do_tx(input logic [7:0] d, output int lat);
      int t = 0;
      @(posedge clk); #1;
      u_if.tx_valid = 1'b1;
      u_if.tx_data  = d;
      @(negedge clk);
      while (!u_if.tx_ready && t < 40) begin
         @(negedge clk);
         t++;
      end
      check("tx_handshake_wait", t < 40, 1);
      sb.push_back('{MODE_PISO, d});
      tx_post(lat);
   endtask

   task automatic do_rx(input logic [7:0] d, input bit with_tx, input logic [7:0] td,
                        input bit uncorr, output int lat);
      int lat2;
      @(posedge clk); #1;
      u_if.rx_req     = 1'b1;
      u_if.err_uncorr = uncorr;
      if (with_tx) begin
         u_if.tx_valid = 1'b1;
         u_if.tx_data  = td;
      end
      sb.push_back('{MODE_SIPO, d});
      if (with_tx) sb.push_back('{MODE_PISO, td});
      @(negedge clk);
      check("rx_req_blocks_tx", u_if.tx_ready, 0);
      @(posedge clk); #1;
      u_if.rx_req = 1'b0;
      serial_in   = d[7];
      for (int i = 6; i >= 0; i--) begin
         @(posedge clk); #1 serial_in = d[i];
      end
      lat = 8;
      @(negedge clk);
      while (!u_if.rx_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      check("rx_err", u_if.rx_err, SCRUB ? uncorr : 1'b0);
      for (int k = 0; k < 3; k++) begin
         check("rx_hold_valid", u_if.rx_valid, 1);
         check("rx_hold_data", u_if.rx_data, d);
         @(negedge clk);
      end
      @(posedge clk); #1;
      u_if.rx_ready   = 1'b1;
      u_if.err_uncorr = 1'b0;
      serial_in       = 1'b0;
      @(posedge clk); #1 u_if.rx_ready = 1'b0;
      @(negedge clk);
      check("rx_idle_after_ack", u_if.busy, 0);
      if (with_tx) begin
         check("tx_ready_after_rx", u_if.tx_ready, 1);
         tx_post(lat2);
         check("tx_after_rx_lat", lat2, 9);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int  lat;
      int  t;
      int  dsnap;
      bit  seen;

      vec[0] = '{0, 8'hDB, 0, 8'h00, 0, 9};
      vec[1] = '{1, 8'h8B, 0, 8'h00, 0, 9};
      vec[2] = '{0, 8'h00, 0, 8'h00, 0, 9};
      vec[3] = '{0, 8'hFF, 0, 8'h00, 0, 9};
      vec[4] = '{1, 8'h3C, 0, 8'h00, 1, 9};
      vec[5] = '{1, 8'h8B, 1, 8'hEF, 0, 9};
      vec[6] = '{0, 8'hA5, 0, 8'h00, 0, 9};

      rst_n           = 1'b0;
      serial_in       = 1'b0;
      u_if.tx_valid   = 1'b0;
      u_if.tx_data    = '0;
      u_if.rx_req     = 1'b0;
      u_if.rx_ready   = 1'b0;
      u_if.err_corr   = 1'b0;
      u_if.err_uncorr = 1'b0;

      #12;
      check("rst_busy", u_if.busy, 0);
      check("rst_tx_ready", u_if.tx_ready, 0);
      check("rst_enable", u_if.reg_enable, 0);
      check("rst_mode", u_if.reg_mode, 0);
      check("rst_rx_valid", u_if.rx_valid, 0);
      check("rst_scrub_cnt", u_if.scrub_cnt, 0);
      @(posedge clk); #1 rst_n = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("idle_tx_ready", u_if.tx_ready, 1);

      for (int i = 0; i < 7; i++) begin
         if (vec[i].is_rx) do_rx(vec[i].data, vec[i].with_tx, vec[i].tx_d, vec[i].uncorr, lat);
         else              do_tx(vec[i].data, lat);
         check($sformatf("vec%0d_latency", i), lat, vec[i].exp_lat);
      end

      // Scrub: correctable error seen in IDLE after a frame leaves a nonzero byte in the register.
      do_rx(8'h6D, 0, 8'h00, 0, lat);
      check("rx_6d_latency", lat, 9);
      @(posedge clk); #1 u_if.err_corr = 1'b1;
      if (SCRUB) sb.push_back('{MODE_PIPO, reg_q});
      seen = 0;
      t = 0;
      while (!seen && t < 10) begin
         @(negedge clk);
         seen = u_if.reg_load && (u_if.reg_mode == MODE_PIPO);
         t++;
      end
      check("scrub_load_seen", seen, SCRUB);
      @(posedge clk); #1 u_if.err_corr = 1'b0;
      @(negedge clk);
      check("scrub_cnt", u_if.scrub_cnt, SCRUB ? 8'd1 : 8'd0);

      // Reset in the middle of TX_SHIFT.
      @(posedge clk); #1;
      u_if.tx_valid = 1'b1;
      u_if.tx_data  = 8'h5A;
      t = 0;
      @(negedge clk);
      while (!u_if.tx_ready && t < 40) begin
         @(negedge clk);
         t++;
      end
      sb.push_back('{MODE_PISO, 8'h5A});
      @(posedge clk); #1 u_if.tx_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("midtx_busy", u_if.busy, 1);
      check("midtx_mode", u_if.reg_mode, MODE_PISO);
      dsnap = done_cnt;
      #2 rst_n = 1'b0;
      #1;
      check("arst_busy", u_if.busy, 0);
      check("arst_enable", u_if.reg_enable, 0);
      check("arst_mode", u_if.reg_mode, 0);
      check("arst_tx_done", u_if.tx_done, 0);
      check("arst_tx_ready", u_if.tx_ready, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (12) @(negedge clk);
      check("no_tx_done_after_rst", done_cnt, dsnap);
      check("post_rst_busy", u_if.busy, 0);
      check("post_rst_tx_ready", u_if.tx_ready, 1);
      check("scoreboard_drained", sb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
